// File: rtl/regfile_dbg_pkg.sv
// Shared types and helpers for the register file debug dump reader.
package regfile_dbg_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} dump_state_t;

  // Address after p in an n-entry file, wrapping from the top register back to 0.
  function automatic int unsigned next_addr(input int unsigned p, input int unsigned n);
    return (p == n - 1) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks an inclusive (possibly wrapping) register range and streams each word out over
// a valid/ready interface, one register read per FETCH cycle.
module regfile_dump_reader
  import regfile_dbg_pkg::*;
#(
  parameter int unsigned NUM_OF_SETS    = 32,
  parameter int unsigned DATA_BUS_WIDTH = 32,
  localparam int unsigned AW = (NUM_OF_SETS > 1) ? $clog2(NUM_OF_SETS) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic                      i_abort,
  input  logic [AW-1:0]             i_first_addr,
  input  logic [AW-1:0]             i_last_addr,
  output logic [AW-1:0]             o_rf_rd_addr,
  input  logic [DATA_BUS_WIDTH-1:0] i_rf_rd_data,
  output logic                      o_out_valid,
  input  logic                      i_out_ready,
  output logic [DATA_BUS_WIDTH-1:0] o_out_data,
  output logic [AW-1:0]             o_out_addr,
  output logic                      o_out_last,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_err
);

  localparam logic [AW:0] NumSets = (AW+1)'(NUM_OF_SETS);

  dump_state_t               r_state, w_state_d;
  logic [AW-1:0]             r_ptr, w_ptr_d;
  logic [AW-1:0]             r_last_q, w_last_q_d;
  logic [DATA_BUS_WIDTH-1:0] r_out_data, w_out_data_d;
  logic [AW-1:0]             r_out_addr, w_out_addr_d;
  logic                      r_out_last, w_out_last_d;
  logic                      r_out_valid, w_out_valid_d;
  logic                      r_err, w_err_d;

  logic          w_range_ok;
  logic [AW-1:0] w_next_ptr;

  // Out-of-range addresses only exist when NUM_OF_SETS is not a power of two.
  assign w_range_ok = ({1'b0, i_first_addr} < NumSets) && ({1'b0, i_last_addr} < NumSets);
  assign w_next_ptr = AW'(next_addr(32'(r_ptr), NUM_OF_SETS));

  always_comb begin
    w_state_d     = r_state;
    w_ptr_d       = r_ptr;
    w_last_q_d    = r_last_q;
    w_out_data_d  = r_out_data;
    w_out_addr_d  = r_out_addr;
    w_out_last_d  = r_out_last;
    w_out_valid_d = r_out_valid;
    w_err_d       = 1'b0;

    if (i_abort && (r_state != IDLE)) begin
      w_state_d     = IDLE;
      w_ptr_d       = '0;
      w_out_valid_d = 1'b0;
      w_out_last_d  = 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (i_start) begin
            if (w_range_ok) begin
              w_ptr_d    = i_first_addr;
              w_last_q_d = i_last_addr;
              w_state_d  = FETCH;
            end else begin
              w_err_d = 1'b1;
            end
          end
        end
        FETCH: begin
          w_out_data_d  = i_rf_rd_data;
          w_out_addr_d  = r_ptr;
          w_out_last_d  = (r_ptr == r_last_q);
          w_out_valid_d = 1'b1;
          w_state_d     = SEND;
        end
        SEND: begin
          if (i_out_ready) begin
            w_out_valid_d = 1'b0;
            w_out_last_d  = 1'b0;
            if (r_out_last) begin
              w_ptr_d   = '0;
              w_state_d = DONE;
            end else begin
              w_ptr_d   = w_next_ptr;
              w_state_d = FETCH;
            end
          end
        end
        DONE: w_state_d = IDLE;
        default: w_state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_last_q    <= '0;
      r_out_data  <= '0;
      r_out_addr  <= '0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_ptr       <= w_ptr_d;
      r_last_q    <= w_last_q_d;
      r_out_data  <= w_out_data_d;
      r_out_addr  <= w_out_addr_d;
      r_out_last  <= w_out_last_d;
      r_out_valid <= w_out_valid_d;
      r_err       <= w_err_d;
    end
  end

  assign o_rf_rd_addr = r_ptr;
  assign o_out_valid  = r_out_valid;
  assign o_out_data   = r_out_data;
  assign o_out_addr   = r_out_addr;
  assign o_out_last   = r_out_last;
  assign o_busy       = (r_state == FETCH) || (r_state == SEND);
  assign o_done       = (r_state == DONE);
  assign o_err        = r_err;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench: a reset-initialised register file model (reg[i] = i+1) feeds the reader.
module tb_regfile_dump_reader;

  localparam int unsigned NS = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, abort, out_ready;
  logic [AW-1:0] first_addr, last_addr, rf_rd_addr, out_addr;
  logic [DW-1:0] rf_rd_data, out_data;
  logic          out_valid, out_last, busy, done, err;

  logic          start24, ready24;
  logic [AW-1:0] first24, last24, rd_addr24, out_addr24;
  logic [DW-1:0] rd_data24, out_data24;
  logic          valid24, last_o24, busy24, done24, err24;

  always #5 clk = ~clk;

  // Register file model: synchronous write, combinational read
  logic [DW-1:0] rf_mem [NS];
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NS); i++) rf_mem[i] <= DW'(i + 1);
    end else if (rf_we) begin
      rf_mem[rf_waddr] <= rf_wdata;
    end
  end
  assign rf_rd_data = rf_mem[rf_rd_addr];
  assign rd_data24  = DW'(rd_addr24) + 1;

  regfile_dump_reader #(.NUM_OF_SETS(32), .DATA_BUS_WIDTH(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
    .i_first_addr(first_addr), .i_last_addr(last_addr),
    .o_rf_rd_addr(rf_rd_addr), .i_rf_rd_data(rf_rd_data),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
    .o_out_addr(out_addr), .o_out_last(out_last), .o_busy(busy), .o_done(done), .o_err(err)
  );

  regfile_dump_reader #(.NUM_OF_SETS(24), .DATA_BUS_WIDTH(32)) dut24 (
    .i_clk(clk), .i_rst(rst), .i_start(start24), .i_abort(1'b0),
    .i_first_addr(first24), .i_last_addr(last24),
    .o_rf_rd_addr(rd_addr24), .i_rf_rd_data(rd_data24),
    .o_out_valid(valid24), .i_out_ready(ready24), .o_out_data(out_data24),
    .o_out_addr(out_addr24), .o_out_last(last_o24), .o_busy(busy24), .o_done(done24),
    .o_err(err24)
  );

  typedef struct {
    logic [AW-1:0] first;
    logic [AW-1:0] last;
    int            n_words;
    int            stall;
    bit            wr7;
  } vec_t;

  int n_cmp = 0;
  int n_fail = 0;

  logic [DW-1:0] shadow [NS];
  logic [AW-1:0] rec_addr [64];
  logic [DW-1:0] rec_data [64];
  logic          rec_last [64];
  int            rec_cyc  [64];
  int            n_rec;
  int            done_cyc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts a dump and follows it until done, recording every handshaken word.
  task automatic do_dump(input vec_t v);
    int            stall_left;
    int            cyc;
    logic [DW-1:0] hold_data;
    logic [AW-1:0] hold_addr;
    n_rec      = 0;
    done_cyc   = -1;
    stall_left = v.stall;
    hold_data  = '0;
    hold_addr  = '0;
    start      = 1'b1;
    first_addr = v.first;
    last_addr  = v.last;
    out_ready  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (cyc < 200) begin
      if (v.wr7) begin
        rf_we    = (cyc == 1);
        rf_waddr = 5'd7;
        rf_wdata = 32'hDEADBEEF;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (out_valid) begin
        if (v.stall > 0 && n_rec == 0 && stall_left < v.stall) begin
          chk("stall_data", out_data, hold_data);
          chk("stall_addr", out_addr, hold_addr);
        end
        hold_data = out_data;
        hold_addr = out_addr;
        if (stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = 1'b1;
          chk("busy_in_send", busy, 1);
          rec_addr[n_rec] = out_addr;
          rec_data[n_rec] = out_data;
          rec_last[n_rec] = out_last;
          rec_cyc[n_rec]  = cyc;
          n_rec++;
        end
      end else begin
        out_ready = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    rf_we = 1'b0;
    if (done_cyc < 0) chk("dump_timeout", 0, 1);
  endtask

  task automatic run_vec(input vec_t v);
    int            a;
    do_dump(v);
    chk("word_count", n_rec, v.n_words);
    for (int k = 0; k < n_rec && k < v.n_words; k++) begin
      a = (int'(v.first) + k) % int'(NS);
      chk("word_addr", rec_addr[k], a);
      chk("word_data", rec_data[k], shadow[a]);
      chk("word_last", rec_last[k], (k == v.n_words - 1));
      chk("word_cycle", rec_cyc[k], 2 + 2 * k + v.stall);
    end
    if (done_cyc >= 0 && n_rec > 0) begin
      chk("done_cycle", done_cyc, rec_cyc[n_rec-1] + 1);
      chk("done_busy", busy, 0);
      chk("done_rd_addr", rf_rd_addr, 0);
    end
    @(negedge clk);
    chk("done_pulse_width", done, 0);
    chk("idle_busy", busy, 0);
    if (v.wr7) shadow[7] = 32'hDEADBEEF;
  endtask

  vec_t vecs [7];
  int   done_seen;

  initial begin
    vecs[0] = '{first: 5'd0,  last: 5'd3,  n_words: 4, stall: 0, wr7: 1'b0};
    vecs[1] = '{first: 5'd30, last: 5'd1,  n_words: 4, stall: 0, wr7: 1'b0};
    vecs[2] = '{first: 5'd5,  last: 5'd5,  n_words: 1, stall: 5, wr7: 1'b0};
    vecs[3] = '{first: 5'd7,  last: 5'd7,  n_words: 1, stall: 0, wr7: 1'b1};
    vecs[4] = '{first: 5'd7,  last: 5'd7,  n_words: 1, stall: 0, wr7: 1'b0};
    vecs[5] = '{first: 5'd31, last: 5'd0,  n_words: 2, stall: 0, wr7: 1'b0};
    vecs[6] = '{first: 5'd10, last: 5'd12, n_words: 3, stall: 0, wr7: 1'b0};
    for (int i = 0; i < int'(NS); i++) shadow[i] = DW'(i + 1);

    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    first_addr = '0; last_addr = '0;
    rf_we = 1'b0; rf_waddr = '0; rf_wdata = '0;
    start24 = 1'b0; ready24 = 1'b1; first24 = '0; last24 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_rd_addr", rf_rd_addr, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_last", out_last, 0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Abort during SEND of the second word of 0..9; a start pulse while busy is ignored
    start = 1'b1; first_addr = 5'd0; last_addr = 5'd9; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; first_addr = 5'd20; last_addr = 5'd20;
    @(negedge clk);
    start = 1'b0;
    chk("abort_fetch_busy", busy, 1);
    @(negedge clk);
    chk("abort_send_valid", out_valid, 1);
    chk("abort_send_addr", out_addr, 1);
    chk("abort_send_data", out_data, 2);
    abort = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    abort = 1'b0; out_ready = 1'b1;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_last", out_last, 0);
    chk("abort_rd_addr", rf_rd_addr, 0);
    done_seen = 0;
    repeat (5) begin
      if (done || busy) done_seen++;
      @(negedge clk);
    end
    chk("abort_no_done", done_seen, 0);
    run_vec('{first: 5'd2, last: 5'd4, n_words: 3, stall: 0, wr7: 1'b0});

    // 24-entry instance: out-of-range starts are rejected with a one-cycle err
    start24 = 1'b1; first24 = 5'd25; last24 = 5'd0;
    @(negedge clk);
    start24 = 1'b0;
    chk("err_first_pulse", err24, 1);
    chk("err_first_busy", busy24, 0);
    @(negedge clk);
    chk("err_first_clear", err24, 0);
    chk("err_first_valid", valid24, 0);
    chk("err_first_busy2", busy24, 0);
    start24 = 1'b1; first24 = 5'd3; last24 = 5'd24;
    @(negedge clk);
    start24 = 1'b0;
    chk("err_last_pulse", err24, 1);
    @(negedge clk);
    chk("err_last_clear", err24, 0);
    // 23..0 wraps at 24, not at 32
    start24 = 1'b1; first24 = 5'd23; last24 = 5'd0;
    @(negedge clk);
    start24 = 1'b0;
    chk("w24_err", err24, 0);
    @(negedge clk);
    chk("w24_v0", valid24, 1);
    chk("w24_a0", out_addr24, 23);
    chk("w24_d0", out_data24, 24);
    chk("w24_l0", last_o24, 0);
    repeat (2) @(negedge clk);
    chk("w24_v1", valid24, 1);
    chk("w24_a1", out_addr24, 0);
    chk("w24_d1", out_data24, 1);
    chk("w24_l1", last_o24, 1);
    @(negedge clk);
    chk("w24_done", done24, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
Debug/readout engine that walks an inclusive address range of the register_file read port and streams each word out over a valid/ready interface. It drives the register file's rd_addr and captures its asynchronous rd_data. It sits beside the register file in the single-cycle core, behind a debug or UART path. It is the reader counterpart to the register file's synchronous write side.

Parameters:
NUM_OF_SETS, 32, number of registers addressed; AW = $clog2(NUM_OF_SETS)
DATA_BUS_WIDTH, 32, word width of rf_rd_data and out_data

Ports:
clk  input  1  single clock, all state on posedge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle request to begin a dump; sampled only in IDLE
abort  input  1  cancels the dump in progress; highest priority after rst
first_addr  input  AW  first register of range, sampled with start
last_addr  input  AW  last register of range, inclusive, sampled with start
rf_rd_addr  output  AW  to register_file rd_addr
rf_rd_data  input  DATA_BUS_WIDTH  from register_file rd_data (combinational)
out_valid  output  1  out_data/out_addr/out_last are valid
out_ready  input  1  consumer accepts the word when high with out_valid
out_data  output  DATA_BUS_WIDTH  captured register value
out_addr  output  AW  index of out_data
out_last  output  1  high with the final word of the range
busy  output  1  high in FETCH/SEND
done  output  1  one-cycle pulse after the last word is accepted
err  output  1  one-cycle pulse when start is rejected for a bad range

Behaviour:
- Reset (rst=1 at posedge): state IDLE; ptr, last_q, rf_rd_addr, out_data, out_addr = 0; out_valid, out_last, busy, done, err = 0.
- rf_rd_addr is registered ptr in all states; it is 0 in IDLE.
- IDLE:
  - start=1 with first_addr and last_addr both < NUM_OF_SETS: ptr<=first_addr, last_q<=last_addr, go to FETCH.
  - start=1 with either address >= NUM_OF_SETS (only possible when NUM_OF_SETS is not a power of 2): err=1 for one cycle, stay in IDLE.
- FETCH (1 cycle): rf_rd_addr==ptr. At the posedge: out_data<=rf_rd_data, out_addr<=ptr, out_last<=(ptr==last_q), out_valid<=1, go to SEND.
- SEND: all out_* outputs are held stable while out_valid && !out_ready. On the handshake:
  - out_valid<=0.
  - If out_last: go to DONE.
  - Otherwise: ptr<=next(ptr), go to FETCH.
- DONE (1 cycle): done=1, busy=0, rf_rd_addr=0, go to IDLE.
- Throughput: 2 cycles per word minimum. Start-to-first-out_valid latency is 2 cycles.
- Wrap: next(p) = (p==NUM_OF_SETS-1) ? 0 : p+1. A range with last_addr < first_addr wraps through the top register to 0. A range with first_addr == last_addr emits exactly one word.
- A start pulse in any state other than IDLE is ignored.
- abort=1 at a posedge in FETCH, SEND or DONE: next state IDLE; out_valid, out_last, busy = 0; no done pulse. A word pending in SEND is dropped.
- Coherency: the word captured is the rf_rd_data value present before the FETCH posedge. A same-cycle register file write to ptr is not reflected; a later write is also not reflected once captured.
- Counting: exactly ((last-first) mod NUM_OF_SETS)+1 words per dump.

Decomposition:
- Package regfile_dbg_pkg holds:
  - typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} dump_state_t
  - function next_addr() implementing the wrap rule
- No sub-module: the FSM and capture registers live in one module. The bench instantiates the existing register_file alongside it.

Test Plan:
- Reset, then start with first=0, last=3, out_ready=1 -> words (addr,data) = (0,1),(1,2),(2,3),(3,4) from reset-initialised register_file; out_last only on addr 3; done pulses 1 cycle after the final handshake; 8 cycles from start to done-1.
- first=30, last=1 -> addrs 30,31,0,1 with data 31,32,1,2; exactly 4 words.
- first=last=5 with out_ready held low for 5 cycles after out_valid -> out_data=6, out_addr=5 stable throughout; single word, then done.
- Write 0xDEADBEEF to reg 7 during the FETCH cycle for addr 7 -> out_data=8 (old value). A second dump of reg 7 returns 0xDEADBEEF.
- abort asserted in SEND of the 2nd word of range 0..9 -> out_valid=0 and busy=0 next cycle, no done; a new start then works normally; start pulses while busy are ignored.
- NUM_OF_SETS=24, first_addr=25 -> err pulses 1 cycle, busy stays 0, no out_valid.
